// File: rtl/number_collision_scorer_if.sv
// Signal bundle between the frame/pixel source, the collision scorer and its observers.
interface number_collision_scorer_if #(
  parameter int NUMBERS      = 3,
  parameter int SCORE_DIGITS = 4
);
  logic                         startOfFrame;
  logic                         playerDR;
  logic [NUMBERS-1:0]           numbersDR;
  logic [NUMBERS-1:0]           showNum;
  logic [NUMBERS-1:0][3:0]      numbersToShow;
  logic                         scoreClear;
  logic [NUMBERS-1:0]           singleHit;
  logic [SCORE_DIGITS-1:0][3:0] scoreBCD;
  logic                         busy;
  logic                         saturated;
  logic [1:0]                   fsm_state;

  // startOfFrame is the only "valid": a commit is taken on that cycle with no
  // backpressure; busy is advisory and a hit committed while busy is not scored.
  modport master (
    output startOfFrame, playerDR, numbersDR, showNum, numbersToShow, scoreClear,
    input  singleHit, scoreBCD, busy, saturated, fsm_state
  );

  modport slave (
    input  startOfFrame, playerDR, numbersDR, showNum, numbersToShow, scoreClear,
    output singleHit, scoreBCD, busy, saturated, fsm_state
  );
endinterface

// File: rtl/number_collision_scorer.sv
// Per-frame player/number overlap detection with a one-hit-per-frame pulse and a
// serial (one digit per clock) saturating BCD score accumulator.
module number_collision_scorer #(
  parameter int NUMBERS      = 3,
  parameter int SCORE_DIGITS = 4
) (
  input  logic                       clk,
  input  logic                       resetN,
  number_collision_scorer_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ADD    = 2'd1,
    COMMIT = 2'd2
  } state_t;

  localparam int KW = (SCORE_DIGITS > 1) ? $clog2(SCORE_DIGITS) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(SCORE_DIGITS - 1);

  logic [NUMBERS-1:0]           overlap;
  logic [NUMBERS-1:0]           hit_flags;
  logic [NUMBERS-1:0]           sel_onehot;
  logic [NUMBERS-1:0]           single_hit;
  logic [3:0]                   sel_value;
  logic [3:0]                   addend;
  logic                         commit_hit;

  state_t                       state, state_n;
  logic [SCORE_DIGITS-1:0][3:0] work, work_n;
  logic [SCORE_DIGITS-1:0][3:0] score, score_n;
  logic [KW-1:0]                k, k_n;
  logic [3:0]                   carry, carry_n;
  logic                         sat, sat_n;
  logic [4:0]                   digit_sum;

  assign overlap = {NUMBERS{bus.playerDR}} & bus.numbersDR & bus.showNum;

  // Walk from the top down so the lowest flagged index is the one that sticks.
  always_comb begin
    sel_onehot = '0;
    sel_value  = '0;
    for (int j = NUMBERS - 1; j >= 0; j--) begin
      if (hit_flags[j]) begin
        sel_onehot    = '0;
        sel_onehot[j] = 1'b1;
        sel_value     = bus.numbersToShow[j];
      end
    end
  end

  assign addend     = (sel_value > 4'd9) ? 4'd9 : sel_value;
  assign commit_hit = bus.startOfFrame & (|hit_flags);

  // Overlap seen on the frame strobe itself is the first pixel of the new frame.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      hit_flags  <= '0;
      single_hit <= '0;
    end else begin
      single_hit <= bus.startOfFrame ? sel_onehot : '0;
      hit_flags  <= bus.startOfFrame ? overlap : (hit_flags | overlap);
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state <= IDLE;
      work  <= '0;
      score <= '0;
      k     <= '0;
      carry <= '0;
      sat   <= 1'b0;
    end else begin
      state <= state_n;
      work  <= work_n;
      score <= score_n;
      k     <= k_n;
      carry <= carry_n;
      sat   <= sat_n;
    end
  end

  always_comb begin
    state_n   = state;
    work_n    = work;
    score_n   = score;
    k_n       = k;
    carry_n   = carry;
    sat_n     = sat;
    digit_sum = {1'b0, work[k]} + {1'b0, carry};

    case (state)
      IDLE: begin
        if (commit_hit) begin
          state_n = ADD;
          work_n  = score;
          k_n     = '0;
          carry_n = addend;
        end
      end
      ADD: begin
        if (digit_sum > 5'd9) begin
          work_n[k] = 4'(digit_sum - 5'd10);
          carry_n   = 4'd1;
        end else begin
          work_n[k] = digit_sum[3:0];
          carry_n   = 4'd0;
        end
        if (k == K_LAST) state_n = COMMIT;
        else             k_n     = k + 1'b1;
      end
      COMMIT: begin
        // A carry out of the top digit means the score overflowed: clamp.
        if (carry != 4'd0) begin
          score_n = {SCORE_DIGITS{4'd9}};
          sat_n   = 1'b1;
        end else begin
          score_n = work;
        end
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase

    if (bus.scoreClear) begin
      score_n = '0;
      sat_n   = 1'b0;
      state_n = IDLE;
    end
  end

  assign bus.singleHit = single_hit;
  assign bus.scoreBCD  = score;
  assign bus.saturated = sat;
  assign bus.busy      = (state != IDLE);
  assign bus.fsm_state = state;

endmodule

// File: tb/tb_number_collision_scorer.sv
// Scoreboard bench: driver tasks update a frame-level score model and queue the
// expected hit pulses and score results; a negedge monitor pops and compares.
module tb_number_collision_scorer;
  localparam int N         = 3;
  localparam int SD        = 4;
  localparam int SW        = 32;
  localparam int MAX_SCORE = 10**SD - 1;

  logic clk    = 1'b0;
  logic resetN = 1'b0;

  number_collision_scorer_if #(.NUMBERS(N), .SCORE_DIGITS(SD)) bus ();

  number_collision_scorer #(.NUMBERS(N), .SCORE_DIGITS(SD)) dut (
    .clk    (clk),
    .resetN (resetN),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic [N-1:0]  hit_q[$];
  logic [SW-1:0] score_q[$];

  int          edge_cnt   = 0;
  int          add_start  = 0;
  int          busy_last  = 0;
  int          score_m    = 0;
  bit          sat_m      = 1'b0;
  logic [N-1:0] frame_hits = '0;

  logic sof_d     = 1'b0;
  logic prev_busy = 1'b0;
  int   busy_cnt  = 0;

  function automatic logic [SW-1:0] pack(input int len, input bit s, input int sc);
    return {8'(len), s, 23'(sc)};
  endfunction

  function automatic int bcd_to_int(input logic [SD-1:0][3:0] b);
    int r = 0;
    for (int i = SD - 1; i >= 0; i--) r = r * 10 + int'(b[i]);
    return r;
  endfunction

  function automatic logic [N-1:0][3:0] rand_vals();
    logic [N-1:0][3:0] v;
    for (int i = 0; i < N; i++) v[i] = 4'($urandom_range(0, 15));
    return v;
  endfunction

  // ---------------- monitor ----------------
  always @(posedge clk) sof_d <= bus.startOfFrame & resetN;

  always @(negedge clk) begin
    logic [N-1:0]  exp_h;
    logic [SW-1:0] ent;
    int            got_sc;
    if (!resetN) begin
      prev_busy = 1'b0;
      busy_cnt  = 0;
    end else begin
      checks++;
      if (sof_d) begin
        if (hit_q.size() == 0) begin
          errors++;
          $display("FAIL single_hit: got %b with nothing expected", bus.singleHit);
        end else begin
          exp_h = hit_q.pop_front();
          if (bus.singleHit !== exp_h) begin
            errors++;
            $display("FAIL single_hit: got %b want %b", bus.singleHit, exp_h);
          end
        end
      end else if (bus.singleHit !== '0) begin
        errors++;
        $display("FAIL stray_single_hit: got %b want 0", bus.singleHit);
      end

      if (bus.busy === 1'b1) busy_cnt++;
      if (prev_busy && bus.busy !== 1'b1) begin
        checks++;
        if (score_q.size() == 0) begin
          errors++;
          $display("FAIL score_result: addition finished with nothing expected");
        end else begin
          ent    = score_q.pop_front();
          got_sc = bcd_to_int(bus.scoreBCD);
          if (got_sc != int'(ent[22:0]) || bus.saturated !== ent[23] ||
              busy_cnt != int'(ent[31:24])) begin
            errors++;
            $display("FAIL score_result: got score=%0d sat=%b busy_cycles=%0d want score=%0d sat=%b busy_cycles=%0d",
                     got_sc, bus.saturated, busy_cnt, int'(ent[22:0]), ent[23], int'(ent[31:24]));
          end
        end
        busy_cnt = 0;
      end
      prev_busy = (bus.busy === 1'b1);
    end
  end

  // ---------------- driver ----------------
  task automatic cycle(input logic sof, input logic pdr, input logic [N-1:0] ndr,
                       input logic [N-1:0] show, input logic [N-1:0][3:0] vals,
                       input logic clr);
    int           e;
    int           j;
    logic [N-1:0] exp_h;
    logic [N-1:0] ov;
    bus.startOfFrame  = sof;
    bus.playerDR      = pdr;
    bus.numbersDR     = ndr;
    bus.showNum       = show;
    bus.numbersToShow = vals;
    bus.scoreClear    = clr;
    e  = edge_cnt + 1;
    ov = pdr ? (ndr & show) : '0;
    if (clr) begin
      if (e <= busy_last && score_q.size() > 0) begin
        score_q[score_q.size() - 1] = pack(e - add_start, 1'b0, 0);
        busy_last = e;
      end
      score_m = 0;
      sat_m   = 1'b0;
    end
    if (sof) begin
      exp_h = '0;
      j     = -1;
      for (int i = N - 1; i >= 0; i--) if (frame_hits[i]) j = i;
      if (j >= 0) exp_h[j] = 1'b1;
      hit_q.push_back(exp_h);
      if (j >= 0 && !clr && e > busy_last) begin
        score_m += (vals[j] > 4'd9) ? 9 : int'(vals[j]);
        if (score_m > MAX_SCORE) begin
          score_m = MAX_SCORE;
          sat_m   = 1'b1;
        end
        score_q.push_back(pack(SD + 1, sat_m, score_m));
        add_start = e;
        busy_last = e + SD + 1;
      end
      frame_hits = ov;
    end else begin
      frame_hits |= ov;
    end
    @(posedge clk);
    edge_cnt++;
    #1;
    if (clr) begin
      checks++;
      if (bcd_to_int(bus.scoreBCD) != 0 || bus.saturated !== 1'b0) begin
        errors++;
        $display("FAIL score_clear: got score=%0d sat=%b want 0 0",
                 bcd_to_int(bus.scoreBCD), bus.saturated);
      end
    end
  endtask

  task automatic idle(input int n);
    repeat (n) cycle(1'b0, 1'b0, '0, '1, '0, 1'b0);
  endtask

  task automatic clear();
    cycle(1'b0, 1'b0, '0, '1, '0, 1'b1);
  endtask

  task automatic hit(input int idx, input int val);
    logic [N-1:0][3:0] v;
    logic [N-1:0]      m;
    v      = '0;
    m      = '0;
    m[idx] = 1'b1;
    v[idx] = 4'(val);
    cycle(1'b0, 1'b1, m, '1, v, 1'b0);
    cycle(1'b1, 1'b0, '0, '1, v, 1'b0);
    idle(SD + 1);
  endtask

  task automatic set_score(input int target);
    int rem;
    clear();
    rem = target;
    while (rem >= 9) begin
      hit(0, 9);
      rem -= 9;
    end
    if (rem > 0) hit(1, rem);
  endtask

  task automatic check_outputs_zero(input string name);
    checks++;
    if (bus.singleHit !== '0 || bus.scoreBCD !== '0 || bus.busy !== 1'b0 ||
        bus.saturated !== 1'b0) begin
      errors++;
      $display("FAIL %s: got hit=%b score=%h busy=%b sat=%b want all 0",
               name, bus.singleHit, bus.scoreBCD, bus.busy, bus.saturated);
    end
  endtask

  initial begin
    logic [N-1:0][3:0] v;
    bus.startOfFrame  = 1'b0;
    bus.playerDR      = 1'b0;
    bus.numbersDR     = '0;
    bus.showNum       = '1;
    bus.numbersToShow = '0;
    bus.scoreClear    = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    check_outputs_zero("reset_state");
    resetN = 1'b1;
    idle(2);

    // single hit on number 1, value 7
    hit(1, 7);

    // number 0 hidden, numbers 0 and 2 overlapped -> number 2 wins
    v = '0; v[0] = 4'd5; v[2] = 4'd3;
    cycle(1'b0, 1'b1, 3'b101, 3'b110, v, 1'b0);
    cycle(1'b1, 1'b0, '0, '1, v, 1'b0);
    idle(SD + 1);

    // frames with no countable overlap
    cycle(1'b1, 1'b1, 3'b000, '1, v, 1'b0);
    cycle(1'b0, 1'b1, 3'b001, 3'b110, v, 1'b0);
    cycle(1'b1, 1'b0, '0, '1, v, 1'b0);
    idle(2);

    // overlap on the frame strobe belongs to the next frame
    v = '0; v[1] = 4'd4;
    cycle(1'b1, 1'b1, 3'b010, '1, v, 1'b0);
    idle(SD + 1);
    cycle(1'b1, 1'b0, '0, '1, v, 1'b0);
    idle(SD + 1);

    // randomized frames, including commits that land while busy
    for (int f = 0; f < 40; f++) begin
      repeat ($urandom_range(1, 8))
        cycle(1'b0, 1'($urandom_range(0, 1)), N'($urandom), N'($urandom), rand_vals(), 1'b0);
      cycle(1'b1, 1'($urandom_range(0, 1)), N'($urandom), N'($urandom), rand_vals(), 1'b0);
    end
    idle(SD + 2);

    // second commit at T+2 of an addition: pulse only, not scored
    v = '0; v[0] = 4'd6; v[2] = 4'd9;
    cycle(1'b0, 1'b1, 3'b001, '1, v, 1'b0);
    cycle(1'b1, 1'b0, '0, '1, v, 1'b0);
    cycle(1'b0, 1'b1, 3'b100, '1, v, 1'b0);
    cycle(1'b1, 1'b0, '0, '1, v, 1'b0);
    idle(SD + 1);

    // carry chains, including a clamped value
    set_score(998);
    hit(2, 5);
    set_score(995);
    hit(0, 12);

    // clear during ADD aborts the addition
    v = '0; v[1] = 4'd8;
    cycle(1'b0, 1'b1, 3'b010, '1, v, 1'b0);
    cycle(1'b1, 1'b0, '0, '1, v, 1'b0);
    idle(1);
    clear();
    idle(SD + 1);

    // saturation, re-saturation, zero value on a saturated score
    set_score(9996);
    hit(1, 8);
    hit(2, 3);
    hit(0, 0);
    clear();
    hit(1, 0);

    // asynchronous reset in the middle of an addition
    hit(0, 4);
    v = '0; v[2] = 4'd6;
    cycle(1'b0, 1'b1, 3'b100, '1, v, 1'b0);
    cycle(1'b1, 1'b0, '0, '1, v, 1'b0);
    idle(1);
    if (score_q.size() > 0) void'(score_q.pop_back());
    #2;
    resetN = 1'b0;
    #1;
    check_outputs_zero("async_reset");
    @(posedge clk);
    #1;
    resetN     = 1'b1;
    score_m    = 0;
    sat_m      = 1'b0;
    busy_last  = 0;
    frame_hits = '0;
    idle(2);
    hit(1, 2);
    idle(4);

    checks++;
    if (hit_q.size() != 0) begin
      errors++;
      $display("FAIL hit_queue_drain: got %0d pending want 0", hit_q.size());
    end
    checks++;
    if (score_q.size() != 0) begin
      errors++;
      $display("FAIL score_queue_drain: got %0d pending want 0", score_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/number_collision_scorer.md
# number_collision_scorer

Downstream companion of the multi-number display stage. It consumes the per-number drawing requests, visibility flags and digit values, and detects pixel overlap with the player sprite during each frame. At frame boundaries it emits the one-cycle `singleHit` pulses that hide a number. It also adds the hit number's value into a saturating BCD score, one digit per clock.

## Interface
Parameters:
- `NUMBERS`, default 3: number of on-screen numbers; must match the display stage.
- `SCORE_DIGITS`, default 4: BCD score digits, least-significant digit at index 0.

Ports:
- `clk`, in, 1: system clock.
- `resetN`, in, 1: reset, asynchronous, active-low.
- `startOfFrame`, in, 1: one-cycle frame-boundary strobe from the VGA controller.
- `playerDR`, in, 1: player sprite drawing request for the current pixel.
- `numbersDR`, in, `[NUMBERS-1:0]`: per-number drawing request for the current pixel.
- `showNum`, in, `[NUMBERS-1:0]`: per-number visibility. A hidden number cannot be hit.
- `numbersToShow`, in, `[NUMBERS-1:0][3:0]`: per-number digit value.
- `scoreClear`, in, 1: synchronous score clear.
- `singleHit`, out, `[NUMBERS-1:0]`: one-hot, one-cycle hit pulse.
- `scoreBCD`, out, `[SCORE_DIGITS-1:0][3:0]`: committed score.
- `busy`, out, 1: a score addition is in progress.
- `saturated`, out, 1: sticky flag; the score has clamped at all 9s.

## Operation
Reset values:
- `singleHit`, `scoreBCD`, `busy`, `saturated`, all hit flags and the working registers reset to 0.
- The FSM resets to IDLE.

Hit accumulation:
- `hitFlags[j]` is set in any cycle where `playerDR & numbersDR[j] & showNum[j]` is true.
- All flags clear on `startOfFrame`.
- An overlap that occurs in the `startOfFrame` cycle itself belongs to the new frame. The flag is set after the clear.

Frame commit, on the `startOfFrame` cycle:
- The lowest index `j` with `hitFlags[j]` set is selected. Only one hit is reported per frame; other flags are discarded.
- `singleHit` is registered to `1<<j`, or to 0 if there is no hit.
- The addend is captured as `numbersToShow[j]`. Values 10–15 clamp to 9.

Scoring FSM:
- IDLE: on a commit with a hit, load the working score from `scoreBCD`, set digit index `k`=0 and carry `c`=addend, then go to ADD.
- ADD, one digit per cycle:
  - `s = work[k] + c`.
  - If `s > 9`, then `work[k] = s-10` and `c = 1`; otherwise `work[k] = s` and `c = 0`.
  - After `k = SCORE_DIGITS-1`, go to COMMIT.
- COMMIT: if a carry remains, set `scoreBCD` to all 9s and set `saturated`. Otherwise copy `work` to `scoreBCD`. Return to IDLE.
- `scoreBCD` never shows a partial sum.
- If the score is already all 9s at load, the addition still runs and saturates again.
- `busy` is high in ADD and in COMMIT.

Boundary conditions:
- A commit with a hit while `busy` is high: `singleHit` still pulses, but the addition is dropped.
- `scoreClear` clears `scoreBCD` and `saturated`, and aborts any addition back to IDLE. It has priority over COMMIT in the same cycle.
- A hit on a number whose value is 0 still pulses `singleHit` and runs the FSM; the score is unchanged.
- An asynchronous reset mid-addition returns every output to its reset value immediately.

## Timing
- `startOfFrame` is sampled at edge T.
- `singleHit` is high during cycle T+1 only.
- ADD occupies cycles T+1 through T+`SCORE_DIGITS`. COMMIT is cycle T+`SCORE_DIGITS`+1.
- The new `scoreBCD` is visible from T+`SCORE_DIGITS`+2.
- `busy` is high from T+1 through T+`SCORE_DIGITS`+1.
- Latency is `SCORE_DIGITS`+2 cycles, far shorter than a frame. Back-to-back commits therefore never collide in normal video timing.
- `numbersToShow` is sampled only in the commit cycle; later changes do not affect an addition in flight.

## Test plan
- **Single hit:** overlap on number 1 (value 7) mid-frame, then `startOfFrame` -> `singleHit`=3'b010 for exactly 1 cycle; `scoreBCD` 0000→0007 at T+6; `busy` high 5 cycles.
- **Priority and visibility:** overlaps on numbers 0 and 2 with `showNum[0]`=0 -> `singleHit`=3'b100; no overlap at all -> `singleHit`=0 and `busy` stays low.
- **Carry chain:** score 0998 plus a hit of value 5 -> 1003; value 12 clamps to 9, so 0995 plus a 12 hit -> 1004.
- **Saturation:** score 9996 plus value 8 -> 9999 with `saturated`=1; a following `scoreClear` -> 0000 with `saturated`=0.
- **Edge events:**
  - An overlap asserted in the `startOfFrame` cycle is reported at the next frame.
  - `scoreClear` during ADD aborts the addition: score 0000, `busy` low next cycle.
  - `resetN` pulsed low mid-ADD -> all outputs 0 asynchronously.
- **Busy drop:** force `startOfFrame` with a hit at T+2 of an addition -> second `singleHit` pulses; only the first value is added.
